bullet_pool: RTL and testbench

- Parametrised pool of N enemy bullets for the battle box.
- Per-slot state: position, size, colour and render flag.
- Each slot moves vertically on a programmable tick and wraps at a lower limit.
- Slots are killed by collision events and refilled through a spawn handshake.
- Two zero-latency read ports: one for the VGA renderer, one for the collision/damage path.
- Adds a run/idle/done state machine and a live-bullet count for the game controller.

---
 rtl/bullet_pkg.sv | 62 ++++++
 rtl/bullet_pool_if.sv | 20 ++
 rtl/bullet_slot_sel.sv | 23 ++
 rtl/bullet_pool.sv | 229 ++++++++++++++++++++++
 tb/tb_bullet_pool.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bullet_pkg.sv
// rtl/bullet_pkg.sv - shared types, state encoding and preset table for the bullet pool
package bullet_pkg;

    localparam int PRESET_W = 8;

    typedef enum logic [1:0] {
        COL_WHITE = 2'd0,
        COL_GREEN = 2'd1,
        COL_BLUE  = 2'd2
    } color_e;

    typedef struct packed {
        logic                render;
        color_e              color;
        logic [PRESET_W-1:0] w;
        logic [PRESET_W-1:0] h;
        logic [PRESET_W-1:0] x;
        logic [PRESET_W-1:0] y;
    } slot_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic slot_t preset_slot(input int i);
        slot_t s;
        s.render = 1'b0;
        s.color  = COL_WHITE;
        s.w      = '0;
        s.h      = '0;
        s.x      = '0;
        s.y      = '0;
        case (i)
            0: begin
                s.render = 1'b1; s.color = COL_GREEN;
                s.w = 8'd16;  s.h = 8'd16;  s.x = 8'd160; s.y = 8'd19;
            end
            1: begin
                s.render = 1'b1; s.color = COL_BLUE;
                s.w = 8'd100; s.h = 8'd100; s.x = 8'd56;  s.y = 8'd19;
            end
            2: begin
                s.render = 1'b1; s.color = COL_WHITE;
                s.w = 8'd16;  s.h = 8'd16;  s.x = 8'd128; s.y = 8'd19;
            end
            default: ;
        endcase
        return s;
    endfunction

    function automatic int preset_count(input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) begin
            if (preset_slot(i).render) c++;
        end
        return c;
    endfunction

endpackage

// File: rtl/bullet_pool_if.sv
// rtl/bullet_pool_if.sv - spawn handshake bundle between the wave generator and the pool
interface bullet_pool_if #(
    parameter int COORD_W = 8
);
    logic                 spawn_valid;
    logic                 spawn_ready;
    logic [2*COORD_W-1:0] spawn_pos;
    logic [2*COORD_W-1:0] spawn_size;
    logic [1:0]           spawn_color;

    modport master (
        output spawn_valid, spawn_pos, spawn_size, spawn_color,
        input  spawn_ready
    );

    modport slave (
        input  spawn_valid, spawn_pos, spawn_size, spawn_color,
        output spawn_ready
    );
endinterface

// File: rtl/bullet_slot_sel.sv
// rtl/bullet_slot_sel.sv - priority encoder picking the lowest inactive slot for a spawn
module bullet_slot_sel #(
    parameter int N_BULLETS = 8,
    parameter int IDX_W     = $clog2(N_BULLETS)
) (
    input  logic [N_BULLETS-1:0] render_i,
    output logic [IDX_W-1:0]     free_idx_o,
    output logic                 any_free_o
);

    // Scan from the top down so the last hit is the lowest free index.
    always_comb begin
        free_idx_o = '0;
        any_free_o = 1'b0;
        for (int i = N_BULLETS - 1; i >= 0; i--) begin
            if (!render_i[i]) begin
                free_idx_o = IDX_W'(i);
                any_free_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bullet_pool.sv
// rtl/bullet_pool.sv - enemy bullet pool: move/wrap, kill, spawn, run/idle/done FSM
// Optional: define BULLET_WRAP_KILL_EN to retire bullets at Y_LIMIT instead of wrapping.
module bullet_pool
    import bullet_pkg::*;
#(
    parameter int N_BULLETS = 8,
    parameter int COORD_W   = 8,
    parameter int STEP      = 5,
    parameter int Y_LIMIT   = 200,
    parameter int Y_RESTART = 1,
    parameter int TICK_DIV  = 1,
    parameter int IDX_W     = $clog2(N_BULLETS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 collide,
    input  logic [IDX_W-1:0]     collide_idx,
    input  logic [IDX_W-1:0]     vga_idx,
    output logic [2*COORD_W-1:0] vga_pos,
    output logic [2*COORD_W-1:0] vga_size,
    output logic [1:0]           vga_color,
    output logic                 vga_render,
    input  logic [IDX_W-1:0]     hit_idx,
    output logic [2*COORD_W-1:0] hit_pos,
    output logic [2*COORD_W-1:0] hit_size,
    output logic [1:0]           hit_color,
    output logic                 hit_render,
    bullet_pool_if.slave         spawn_if,
    output logic [IDX_W:0]       active_count,
    output logic                 wave_done
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [IDX_W:0] COUNT_RST = (IDX_W + 1)'(preset_count(N_BULLETS));

    state_e st_q, st_d;

    logic [N_BULLETS-1:0] render_q, render_d;
    logic [1:0]           color_q [N_BULLETS];
    logic [1:0]           color_d [N_BULLETS];
    logic [COORD_W-1:0]   w_q [N_BULLETS];
    logic [COORD_W-1:0]   w_d [N_BULLETS];
    logic [COORD_W-1:0]   h_q [N_BULLETS];
    logic [COORD_W-1:0]   h_d [N_BULLETS];
    logic [COORD_W-1:0]   x_q [N_BULLETS];
    logic [COORD_W-1:0]   x_d [N_BULLETS];
    logic [COORD_W-1:0]   y_q [N_BULLETS];
    logic [COORD_W-1:0]   y_d [N_BULLETS];

    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [IDX_W:0]       active_count_q, popcnt;

    logic [N_BULLETS-1:0] pre_render;
    logic [1:0]           pre_color [N_BULLETS];
    logic [COORD_W-1:0]   pre_w [N_BULLETS];
    logic [COORD_W-1:0]   pre_h [N_BULLETS];
    logic [COORD_W-1:0]   pre_x [N_BULLETS];
    logic [COORD_W-1:0]   pre_y [N_BULLETS];

    logic                 in_run, move_tick, kill_en, spawn_fire, any_free;
    logic [IDX_W-1:0]     free_idx;

    for (genvar g = 0; g < N_BULLETS; g++) begin : g_preset
        localparam slot_t PRE = preset_slot(g);
        assign pre_render[g] = PRE.render;
        assign pre_color[g]  = PRE.color;
        assign pre_w[g]      = COORD_W'(PRE.w);
        assign pre_h[g]      = COORD_W'(PRE.h);
        assign pre_x[g]      = COORD_W'(PRE.x);
        assign pre_y[g]      = COORD_W'(PRE.y);
    end

    bullet_slot_sel #(
        .N_BULLETS (N_BULLETS),
        .IDX_W     (IDX_W)
    ) u_slot_sel (
        .render_i   (render_q),
        .free_idx_o (free_idx),
        .any_free_o (any_free)
    );

    always_comb begin
        popcnt = '0;
        for (int i = 0; i < N_BULLETS; i++) begin
            popcnt = popcnt + (IDX_W + 1)'(render_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    // DONE is decided on the next value of active_count, i.e. the live population now.
    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_IDLE: if (run) st_d = ST_RUN;
            ST_RUN: begin
                if (!run)             st_d = ST_IDLE;
                else if (popcnt == '0) st_d = ST_DONE;
            end
            ST_DONE: if (!run) st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_run               = (st_q == ST_RUN);
        wave_done            = (st_q == ST_DONE);
        spawn_if.spawn_ready = in_run && any_free;
    end

    assign move_tick  = in_run && (tick_q == TICK_W'(TICK_DIV - 1));
    assign kill_en    = in_run && collide && (32'(collide_idx) < N_BULLETS);
    assign spawn_fire = spawn_if.spawn_valid && spawn_if.spawn_ready;

    always_comb begin
        tick_d = '0;
        if (in_run && !move_tick) tick_d = tick_q + 1'b1;
    end

    always_comb begin
        logic [COORD_W:0] sum;
        logic             wrap;
        sum      = '0;
        wrap     = 1'b0;
        render_d = render_q;
        color_d  = color_q;
        w_d      = w_q;
        h_d      = h_q;
        x_d      = x_q;
        y_d      = y_q;
        if (st_q == ST_IDLE) begin
            render_d = pre_render;
            color_d  = pre_color;
            w_d      = pre_w;
            h_d      = pre_h;
            x_d      = pre_x;
            y_d      = pre_y;
        end else if (in_run) begin
            for (int i = 0; i < N_BULLETS; i++) begin
                sum  = {1'b0, y_q[i]} + (COORD_W + 1)'(STEP);
                wrap = (32'(y_q[i]) >= Y_LIMIT) || sum[COORD_W];
                if (render_q[i]) begin
                    if (kill_en && (collide_idx == IDX_W'(i))) begin
                        render_d[i] = 1'b0;
                    end else if (move_tick) begin
                        if (wrap) begin
`ifdef BULLET_WRAP_KILL_EN
                            render_d[i] = 1'b0;
`else
                            y_d[i] = COORD_W'(Y_RESTART);
`endif
                        end else begin
                            y_d[i] = sum[COORD_W-1:0];
                        end
                    end
                end else if (spawn_fire && (free_idx == IDX_W'(i))) begin
                    render_d[i] = 1'b1;
                    color_d[i]  = spawn_if.spawn_color;
                    x_d[i]      = spawn_if.spawn_pos[2*COORD_W-1:COORD_W];
                    y_d[i]      = spawn_if.spawn_pos[COORD_W-1:0];
                    w_d[i]      = spawn_if.spawn_size[2*COORD_W-1:COORD_W];
                    h_d[i]      = spawn_if.spawn_size[COORD_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            render_q       <= pre_render;
            tick_q         <= '0;
            active_count_q <= COUNT_RST;
            for (int i = 0; i < N_BULLETS; i++) begin
                color_q[i] <= pre_color[i];
                w_q[i]     <= pre_w[i];
                h_q[i]     <= pre_h[i];
                x_q[i]     <= pre_x[i];
                y_q[i]     <= pre_y[i];
            end
        end else begin
            render_q       <= render_d;
            tick_q         <= tick_d;
            active_count_q <= popcnt;
            for (int i = 0; i < N_BULLETS; i++) begin
                color_q[i] <= color_d[i];
                w_q[i]     <= w_d[i];
                h_q[i]     <= h_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
            end
        end
    end

    assign active_count = active_count_q;

    // Out-of-range indices match no slot and read back as zero.
    always_comb begin
        vga_pos    = '0;
        vga_size   = '0;
        vga_color  = '0;
        vga_render = 1'b0;
        hit_pos    = '0;
        hit_size   = '0;
        hit_color  = '0;
        hit_render = 1'b0;
        for (int i = 0; i < N_BULLETS; i++) begin
            if (vga_idx == IDX_W'(i)) begin
                vga_pos    = {x_q[i], y_q[i]};
                vga_size   = {w_q[i], h_q[i]};
                vga_color  = color_q[i];
                vga_render = render_q[i];
            end
            if (hit_idx == IDX_W'(i)) begin
                hit_pos    = {x_q[i], y_q[i]};
                hit_size   = {w_q[i], h_q[i]};
                hit_color  = color_q[i];
                hit_render = render_q[i];
            end
        end
    end

endmodule

// File: tb/tb_bullet_pool.sv
// tb/tb_bullet_pool.sv - directed self-checking bench for bullet_pool
`timescale 1ns/1ps
module tb_bullet_pool;

    localparam int N  = 8;
    localparam int CW = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          collide = 1'b0;
    logic [IW-1:0] collide_idx = '0;
    logic [IW-1:0] vga_idx = '0;
    logic [IW-1:0] hit_idx = '0;
    logic [2*CW-1:0] vga_pos, vga_size, hit_pos, hit_size;
    logic [1:0]    vga_color, hit_color;
    logic          vga_render, hit_render, wave_done;
    logic [IW:0]   active_count;

    int checks = 0;
    int failures = 0;

    bullet_pool_if #(.COORD_W(CW)) sp_if ();

    bullet_pool dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .collide      (collide),
        .collide_idx  (collide_idx),
        .vga_idx      (vga_idx),
        .vga_pos      (vga_pos),
        .vga_size     (vga_size),
        .vga_color    (vga_color),
        .vga_render   (vga_render),
        .hit_idx      (hit_idx),
        .hit_pos      (hit_pos),
        .hit_size     (hit_size),
        .hit_color    (hit_color),
        .hit_render   (hit_render),
        .spawn_if     (sp_if.slave),
        .active_count (active_count),
        .wave_done    (wave_done)
    );

    always #50 clk = ~clk;

    typedef struct {
        int         idx;
        logic       r;
        logic [1:0] c;
        logic [7:0] w, h, x, y;
    } vec_t;

    vec_t preset_tbl[N];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_slot(input string nm, input int idx, input logic r, input logic [1:0] c,
                            input logic [7:0] w, input logic [7:0] h,
                            input logic [7:0] x, input logic [7:0] y);
        hit_idx = IW'(idx);
        #1;
        chk(nm, {hit_render, hit_color, hit_size, hit_pos}, {r, c, w, h, x, y});
    endtask

    task automatic chk_x(input string nm, input int idx, input logic [7:0] x);
        hit_idx = IW'(idx);
        #1;
        chk(nm, {hit_render, hit_pos[15:8]}, {1'b1, x});
    endtask

    task automatic chk_presets(input string nm);
        for (int i = 0; i < N; i++) begin
            vga_idx = IW'(preset_tbl[i].idx);
            #1;
            chk($sformatf("%s_slot%0d", nm, i), {vga_render, vga_color, vga_size, vga_pos},
                {preset_tbl[i].r, preset_tbl[i].c, preset_tbl[i].w, preset_tbl[i].h,
                 preset_tbl[i].x, preset_tbl[i].y});
        end
    endtask

    function automatic int ynext(input int y);
        return (y >= 200) ? 1 : y + 5;
    endfunction

    int yexp;
    int ycur;

    initial begin
        preset_tbl[0] = '{0, 1'b1, 2'd1, 8'd16,  8'd16,  8'd160, 8'd19};
        preset_tbl[1] = '{1, 1'b1, 2'd2, 8'd100, 8'd100, 8'd56,  8'd19};
        preset_tbl[2] = '{2, 1'b1, 2'd0, 8'd16,  8'd16,  8'd128, 8'd19};
        for (int i = 3; i < N; i++) preset_tbl[i] = '{i, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 8'd0};

        sp_if.spawn_valid = 1'b0;
        sp_if.spawn_pos   = '0;
        sp_if.spawn_size  = '0;
        sp_if.spawn_color = '0;

        // Reset state
        step();
        chk_presets("rst");
        chk("rst_active_count", active_count, 3);
        chk("rst_wave_done", wave_done, 0);
        rst_n = 1'b1;
        step();
        step();
        chk("idle_spawn_ready", sp_if.spawn_ready, 0);
        chk_slot("idle_no_move", 0, 1'b1, 2'd1, 8'd16, 8'd16, 8'd160, 8'd19);

        // Movement and wrap on slot 0
        run = 1'b1;
        step();
        yexp = 19;
        for (int k = 0; k < 42; k++) begin
            hit_idx = 3'd0;
            #1;
            chk($sformatf("move_y_k%0d", k), hit_pos[7:0], yexp[7:0]);
            step();
            yexp = ynext(yexp);
        end
        chk("run_spawn_ready", sp_if.spawn_ready, 1);
        chk("run_active_count", active_count, 3);

        // Kill slot 2
        ycur = yexp;
        collide = 1'b1;
        collide_idx = 3'd2;
        step();
        collide = 1'b0;
        chk_slot("kill2_slot2", 2, 1'b0, 2'd0, 8'd16, 8'd16, 8'd128, ycur[7:0]);
        hit_idx = 3'd0;
        #1;
        chk("kill2_slot0_moves", hit_pos[7:0], 8'(ynext(ycur)));
        chk("kill2_count_lag", active_count, 3);
        step();
        chk("kill2_count", active_count, 2);
        chk_slot("kill2_frozen", 2, 1'b0, 2'd0, 8'd16, 8'd16, 8'd128, ycur[7:0]);

        // Kill 0 and 1 -> DONE
        collide = 1'b1;
        collide_idx = 3'd0;
        step();
        collide_idx = 3'd1;
        step();
        collide = 1'b0;
        chk("done_pending", wave_done, 0);
        step();
        chk("done_wave_done", wave_done, 1);
        chk("done_spawn_ready", sp_if.spawn_ready, 0);
        chk("done_active_count", active_count, 0);

        // run=0 -> IDLE with presets
        run = 1'b0;
        step();
        step();
        chk_presets("reload");
        step();
        chk("reload_active_count", active_count, 3);
        chk("reload_wave_done", wave_done, 0);

        // Collide slot 0 and spawn in the same cycle
        run = 1'b1;
        step();
        collide = 1'b1;
        collide_idx = 3'd0;
        sp_if.spawn_valid = 1'b1;
        sp_if.spawn_pos   = {8'd40, 8'd50};
        sp_if.spawn_size  = {8'd8, 8'd9};
        sp_if.spawn_color = 2'd3;
        #1;
        chk("sp_ready_before", sp_if.spawn_ready, 1);
        step();
        collide = 1'b0;
        sp_if.spawn_valid = 1'b0;
        chk_slot("sp_slot3", 3, 1'b1, 2'd3, 8'd8, 8'd9, 8'd40, 8'd50);
        chk_slot("sp_slot0_killed", 0, 1'b0, 2'd1, 8'd16, 8'd16, 8'd160, 8'd19);
        chk_slot("sp_slot1_moved", 1, 1'b1, 2'd2, 8'd100, 8'd100, 8'd56, 8'd24);
        step();
        chk_slot("sp_slot3_moves", 3, 1'b1, 2'd3, 8'd8, 8'd9, 8'd40, 8'd55);

        // Fill free slots 0,4,5,6,7
        sp_if.spawn_valid = 1'b1;
        sp_if.spawn_size  = {8'd4, 8'd4};
        sp_if.spawn_color = 2'd1;
        for (int k = 0; k < 5; k++) begin
            sp_if.spawn_pos = {8'(100 + k), 8'd10};
            step();
        end
        sp_if.spawn_pos = {8'd250, 8'd10};
        #1;
        chk("full_spawn_ready", sp_if.spawn_ready, 0);
        step();
        step();
        chk("full_active_count", active_count, 8);
        chk_x("full_x0", 0, 8'd100);
        chk_x("full_x4", 4, 8'd101);
        chk_x("full_x5", 5, 8'd102);
        chk_x("full_x6", 6, 8'd103);
        chk_x("full_x7", 7, 8'd104);

        // Kill slot 5, held spawn lands there next cycle
        collide = 1'b1;
        collide_idx = 3'd5;
        sp_if.spawn_pos = {8'd200, 8'd10};
        step();
        collide = 1'b0;
        #1;
        chk("refill_ready", sp_if.spawn_ready, 1);
        hit_idx = 3'd5;
        #1;
        chk("refill_slot5_dead", hit_render, 0);
        step();
        sp_if.spawn_valid = 1'b0;
        chk_x("refill_x5", 5, 8'd200);
        chk("refill_ready_after", sp_if.spawn_ready, 0);

        // Asynchronous reset mid-RUN
        step();
        #20;
        rst_n = 1'b0;
        #1;
        chk_slot("async_slot1", 1, 1'b1, 2'd2, 8'd100, 8'd100, 8'd56, 8'd19);
        chk_slot("async_slot3", 3, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        chk("async_active_count", active_count, 3);
        chk("async_spawn_ready", sp_if.spawn_ready, 0);
        chk("async_wave_done", wave_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
